// File: rtl/data_mem_responder.sv
// Data-memory responder: buffers EX load/store requests onto an in-order
// word bus and returns one data_ok per request, in order.
package data_mem_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;
endpackage

module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  mem_size_t   size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P = AW'(1);

  logic             buf_valid;
  logic             buf_wr;
  logic [31:0]      buf_addr;
  logic [3:0]       buf_wstrb;
  logic [31:0]      buf_wdata;
  logic [AW:0]      cnt;
  logic [AW:0]      fifo_cnt;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [DEPTH-1:0] tag_q;

  logic        accept;
  logic        grant;
  logic        fifo_empty;
  logic        pop;
  logic [3:0]  fmt_wstrb;
  logic [31:0] fmt_wdata;

  assign addr_ok    = !buf_valid && (cnt < FULL);
  assign accept     = req && addr_ok;
  assign grant      = buf_valid && bus_gnt;
  assign fifo_empty = (fifo_cnt == '0);
  // A response with nothing outstanding is dropped, not popped.
  assign pop        = bus_rvalid && !fifo_empty;

  assign bus_req   = buf_valid;
  assign bus_wr    = buf_wr;
  assign bus_addr  = buf_addr;
  assign bus_wstrb = buf_wstrb;
  assign bus_wdata = buf_wdata;

  always_comb begin
    fmt_wstrb = 4'b1111;
    fmt_wdata = wdata;
    unique case (1'b1)
      (size == MEM_BYTE): begin
        fmt_wstrb = 4'b0001 << addr[1:0];
        fmt_wdata = {4{wdata[7:0]}};
      end
      (size == MEM_HALF): begin
        fmt_wstrb = 4'b0011 << {addr[1], 1'b0};
        fmt_wdata = {2{wdata[15:0]}};
      end
      default: begin
        fmt_wstrb = 4'b1111;
        fmt_wdata = wdata;
      end
    endcase
    if (!wr) fmt_wstrb = 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_wr    <= 1'b0;
      buf_addr  <= '0;
      buf_wstrb <= '0;
      buf_wdata <= '0;
      cnt       <= '0;
      fifo_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_q     <= '0;
      data_ok   <= 1'b0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        buf_valid <= 1'b1;
        buf_wr    <= wr;
        buf_addr  <= {addr[31:2], 2'b00};
        buf_wstrb <= fmt_wstrb;
        buf_wdata <= fmt_wdata;
      end else if (grant) begin
        buf_valid <= 1'b0;
      end

      unique case ({accept, pop})
        2'b10:   cnt <= cnt + ONE_C;
        2'b01:   cnt <= cnt - ONE_C;
        default: cnt <= cnt;
      endcase

      if (grant) begin
        tag_q[wr_ptr] <= buf_wr;
        wr_ptr        <= wr_ptr + ONE_P;
      end
      if (pop) rd_ptr <= rd_ptr + ONE_P;

      unique case ({grant, pop})
        2'b10:   fifo_cnt <= fifo_cnt + ONE_C;
        2'b01:   fifo_cnt <= fifo_cnt - ONE_C;
        default: fifo_cnt <= fifo_cnt;
      endcase

      data_ok <= pop;
      if (pop) rdata <= tag_q[rd_ptr] ? 32'b0 : bus_rdata;
    end
  end

  a_no_orphan_rvalid: assert property (
    @(posedge clk) disable iff (reset) !(bus_rvalid && fifo_empty)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed scenarios
// followed by randomized traffic against a counting reference model.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  mem_size_t   size = MEM_WORD;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  data_mem_responder #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req(req), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_t;

  bus_t        exp_bus[$];
  logic        pend_wr[$];
  logic [31:0] exp_resp[$];
  int acc_n, gnt_n, rv_n, dok_n;
  int checks = 0;
  int errors = 0;
  logic hold_v = 1'b0;
  bus_t hold;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic bus_t expect_bus(input logic w, input mem_size_t s,
                                      input logic [31:0] a,
                                      input logic [31:0] d);
    bus_t b;
    b.wr    = w;
    b.addr  = a & 32'hFFFF_FFFC;
    b.wstrb = 4'hF;
    b.wdata = d;
    if (s == MEM_BYTE) begin
      b.wstrb = 4'(1 << (a % 4));
      b.wdata = (d & 32'hFF) * 32'h0101_0101;
    end else if (s == MEM_HALF) begin
      b.wstrb = 4'(3 << (a & 2));
      b.wdata = (d & 32'hFFFF) * 32'h0001_0001;
    end
    if (!w) b.wstrb = 4'h0;
    return b;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      exp_bus.delete();
      pend_wr.delete();
      exp_resp.delete();
      acc_n = 0; gnt_n = 0; rv_n = 0; dok_n = 0;
      hold_v = 1'b0;
    end else begin
      if (data_ok) begin
        if (exp_resp.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_data_ok: got 1 expected 0 at %0t", $time);
        end else begin
          chk("rdata", rdata, exp_resp.pop_front());
        end
        dok_n++;
      end
      chk("bus_req_model", {31'b0, bus_req}, {31'b0, acc_n != gnt_n});
      chk("addr_ok_model", {31'b0, addr_ok},
          {31'b0, (acc_n == gnt_n) && (acc_n - dok_n < 4)});
      if (hold_v) begin
        chk("hold_addr", bus_addr, hold.addr);
        chk("hold_wr", {31'b0, bus_wr}, {31'b0, hold.wr});
        chk("hold_wstrb", {28'b0, bus_wstrb}, {28'b0, hold.wstrb});
        chk("hold_wdata", bus_wdata, hold.wdata);
      end
      if (bus_req && bus_gnt) begin
        if (exp_bus.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_grant: got bus_req=1 expected 0 at %0t", $time);
          pend_wr.push_back(bus_wr);
        end else begin
          bus_t b;
          b = exp_bus.pop_front();
          chk("bus_addr", bus_addr, b.addr);
          chk("bus_wr", {31'b0, bus_wr}, {31'b0, b.wr});
          chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, b.wstrb});
          if (b.wr) chk("bus_wdata", bus_wdata, b.wdata);
          pend_wr.push_back(b.wr);
        end
        gnt_n++;
      end
      hold_v = bus_req && !bus_gnt;
      hold.addr  = bus_addr;
      hold.wr    = bus_wr;
      hold.wstrb = bus_wstrb;
      hold.wdata = bus_wdata;
      if (bus_rvalid) begin
        if (pend_wr.size() != 0)
          exp_resp.push_back(pend_wr.pop_front() ? 32'b0 : bus_rdata);
        rv_n++;
      end
      if (req && addr_ok) begin
        exp_bus.push_back(expect_bus(wr, size, addr, wdata));
        acc_n++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting edge.
  task automatic issue(input logic w, input mem_size_t s,
                       input logic [31:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    req = 1'b1; wr = w; size = s; addr = a; wdata = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (addr_ok) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_timeout: got addr_ok=0 expected 1 at %0t", $time);
    end
    tick();
    req = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    req = 1'b0;
    bus_gnt = 1'b1;
    for (int n = 0; n < 200; n++) begin
      bus_rvalid = (gnt_n > rv_n);
      bus_rdata = $urandom;
      @(negedge clk);
      if (acc_n == dok_n) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d responses expected %0d", dok_n, acc_n);
    end
    tick();
    bus_rvalid = 1'b0;
  endtask

  logic [31:0] dv [4] = '{32'h0BAD_0001, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_0004};
  logic [31:0] ev [4] = '{32'h0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0};

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    repeat (10) begin
      @(negedge clk);
      chk("idle_addr_ok", {31'b0, addr_ok}, 32'd1);
      chk("idle_bus_req", {31'b0, bus_req}, 32'd0);
      chk("idle_data_ok", {31'b0, data_ok}, 32'd0);
      chk("idle_rdata", rdata, 32'd0);
    end
    tick();

    // single byte load, immediate grant, response at T+2
    bus_gnt = 1'b1;
    issue(1'b0, MEM_BYTE, 32'h1003, 32'h0);
    @(negedge clk);
    chk("ld_bus_req", {31'b0, bus_req}, 32'd1);
    chk("ld_bus_addr", bus_addr, 32'h1000);
    chk("ld_wstrb", {28'b0, bus_wstrb}, 32'd0);
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'hAABB_CCDD;
    @(negedge clk);
    chk("ld_early_data_ok", {31'b0, data_ok}, 32'd0);
    tick();
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("ld_data_ok", {31'b0, data_ok}, 32'd1);
    chk("ld_rdata", rdata, 32'hAABB_CCDD);
    tick();

    // half store
    issue(1'b1, MEM_HALF, 32'h22, 32'h1234);
    @(negedge clk);
    chk("st_bus_wr", {31'b0, bus_wr}, 32'd1);
    chk("st_wstrb", {28'b0, bus_wstrb}, 32'hC);
    chk("st_wdata", bus_wdata, 32'h1234_1234);
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("st_data_ok", {31'b0, data_ok}, 32'd1);
    chk("st_rdata", rdata, 32'd0);
    tick();

    // grant withheld for 5 cycles
    bus_gnt = 1'b0;
    issue(1'b1, MEM_WORD, 32'h43, 32'hCAFE_F00D);
    repeat (5) begin
      @(negedge clk);
      chk("stall_bus_req", {31'b0, bus_req}, 32'd1);
      chk("stall_addr_ok", {31'b0, addr_ok}, 32'd0);
      chk("stall_bus_addr", bus_addr, 32'h40);
      tick();
    end
    bus_gnt = 1'b1;
    @(negedge clk);
    chk("gnt_bus_req", {31'b0, bus_req}, 32'd1);
    tick();
    @(negedge clk);
    chk("post_gnt_addr_ok", {31'b0, addr_ok}, 32'd1);
    chk("post_gnt_bus_req", {31'b0, bus_req}, 32'd0);
    tick();
    drain();

    // fill to DEPTH with responses withheld
    bus_gnt = 1'b1;
    for (int i = 0; i < 4; i++)
      issue(1'b0, MEM_WORD, 32'h100 + 32'(i * 4), 32'h0);
    tick();
    req = 1'b1; wr = 1'b0; size = MEM_WORD; addr = 32'h200;
    @(negedge clk);
    chk("full_addr_ok", {31'b0, addr_ok}, 32'd0);
    chk("full_cnt", 32'(dut.cnt), 32'd4);
    tick();
    @(negedge clk);
    chk("full_addr_ok2", {31'b0, addr_ok}, 32'd0);
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
    tick();
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("free_data_ok", {31'b0, data_ok}, 32'd1);
    chk("free_cnt", 32'(dut.cnt), 32'd3);
    chk("free_addr_ok", {31'b0, addr_ok}, 32'd1);
    tick();
    req = 1'b0;
    drain();

    // ST/LD/LD/ST with bunched responses
    issue(1'b1, MEM_BYTE, 32'h301, 32'h5A);
    issue(1'b0, MEM_HALF, 32'h302, 32'h0);
    issue(1'b0, MEM_WORD, 32'h304, 32'h0);
    issue(1'b1, MEM_WORD, 32'h308, 32'h0102_0304);
    tick();
    for (int i = 0; i < 5; i++) begin
      bus_rvalid = (i < 4);
      bus_rdata = (i < 4) ? dv[i] : 32'h0;
      @(negedge clk);
      if (i > 0) begin
        chk("burst_data_ok", {31'b0, data_ok}, 32'd1);
        chk("burst_rdata", rdata, ev[i-1]);
      end
      tick();
    end
    bus_rvalid = 1'b0;

    // reset with requests in flight
    issue(1'b0, MEM_WORD, 32'h400, 32'h0);
    issue(1'b1, MEM_WORD, 32'h404, 32'h77);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("rst_data_ok", {31'b0, data_ok}, 32'd0);
      chk("rst_cnt", 32'(dut.cnt), 32'd0);
      chk("rst_addr_ok", {31'b0, addr_ok}, 32'd1);
      tick();
    end

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      req = 1'($urandom % 2);
      wr = 1'($urandom % 2);
      size = mem_size_t'($urandom % 3);
      addr = $urandom;
      wdata = $urandom;
      bus_gnt = ($urandom % 3) != 0;
      bus_rvalid = (gnt_n > rv_n) && (($urandom % 3) != 0);
      bus_rdata = $urandom;
      tick();
    end
    req = 1'b0;
    drain();
    chk("queues_empty", 32'(exp_bus.size() + pend_wr.size() + exp_resp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
